// File: rtl/mips32_pkg.sv
// mips32_pkg: shared loader state encoding and MIPS32 constants.
package mips32_pkg;
  typedef enum logic [2:0] {IDLE, LEN_LO, DATA, CKSUM, START, ERR} ld_state_t;
  localparam logic [5:0] HLT_OPCODE = 6'h3f;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/mips32_prog_loader_if.sv
// mips32_prog_loader_if: byte stream, memory write port and core control of the program loader.
interface mips32_prog_loader_if #(parameter int ADDR_W = 10);
  logic in_valid;
  logic [7:0] in_data;
  logic in_ready;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic cpu_hold;
  logic cpu_start;
  logic busy;
  logic err;
  modport master (output in_valid, in_data, input in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, cpu_start, busy, err);
  modport slave (input in_valid, in_data, output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, cpu_start, busy, err);
endinterface

// File: rtl/mips32_byte_packer.sv
// mips32_byte_packer: packs bytes MSB-first into 32-bit words with a one-cycle word_valid pulse.
module mips32_byte_packer import mips32_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic [1:0]  o_cnt,
  output logic [31:0] o_word,
  output logic        o_word_valid
);
  logic [1:0] r_cnt;
  logic [31:0] r_shift;
  logic r_word_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 2'd0;
      r_shift <= 32'd0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= i_valid && (r_cnt == 2'(WORD_BYTES - 1));
      if (i_valid) begin
        r_shift <= {r_shift[23:0], i_byte};
        r_cnt <= r_cnt + 2'd1;
      end
    end
  end
  assign o_cnt = r_cnt;
  assign o_word = r_shift;
  assign o_word_valid = r_word_valid;
endmodule

// File: rtl/mips32_prog_loader.sv
// mips32_prog_loader: framed byte-stream loader writing words from address 0, then releasing the core.
// Optional trailing XOR checksum enabled by MIPS32_LOADER_CKSUM_EN.
module mips32_prog_loader import mips32_pkg::*; #(
  parameter int ADDR_W = 10
) (
  input logic clk1,
  input logic rst,
  mips32_prog_loader_if.slave bus
);
  localparam logic [16:0] MAX_N = 17'(2**ADDR_W);
  ld_state_t r_state;
  logic [7:0] r_len_hi;
  logic [15:0] r_n;
  logic [ADDR_W:0] r_wcnt;
  logic [ADDR_W-1:0] r_addr;
  logic r_hold, r_start, r_err;
`ifdef MIPS32_LOADER_CKSUM_EN
  logic [7:0] r_sum;
`endif
  logic w_acc, w_pack, w_word_done, w_last, w_we;
  logic [1:0] w_cnt;
  logic [15:0] w_n;
  logic [31:0] w_word;
  assign w_acc = bus.in_valid & bus.in_ready;
  assign w_n = {r_len_hi, bus.in_data};
  assign w_pack = w_acc & (r_state == DATA);
  assign w_word_done = w_pack & (w_cnt == 2'd3);
  assign w_last = w_word_done & ((17'(r_wcnt) + 17'd1) == {1'b0, r_n});
  mips32_byte_packer u_packer (
    .clk(clk1), .rst(rst), .i_valid(w_pack), .i_byte(bus.in_data),
    .o_cnt(w_cnt), .o_word(w_word), .o_word_valid(w_we)
  );
  always_ff @(posedge clk1) begin
    if (rst) begin
      r_state <= IDLE;
      r_len_hi <= 8'd0;
      r_n <= 16'd0;
      r_wcnt <= '0;
      r_addr <= '0;
      r_hold <= 1'b1;
      r_start <= 1'b0;
      r_err <= 1'b0;
`ifdef MIPS32_LOADER_CKSUM_EN
      r_sum <= 8'd0;
`endif
    end else begin
      r_start <= 1'b0;
      case (r_state)
        IDLE: if (w_acc) begin
          r_len_hi <= bus.in_data;
          r_state <= LEN_LO;
          r_hold <= 1'b1;
          r_err <= 1'b0;
`ifdef MIPS32_LOADER_CKSUM_EN
          r_sum <= 8'd0;
`endif
        end
        LEN_LO: if (w_acc) begin
          r_n <= w_n;
          r_wcnt <= '0;
          if ({1'b0, w_n} > MAX_N) begin
            r_state <= ERR;
            r_err <= 1'b1;
          end else if (w_n == 16'd0) begin
`ifdef MIPS32_LOADER_CKSUM_EN
            r_state <= CKSUM;
`else
            r_state <= START;
            r_start <= 1'b1;
            r_hold <= 1'b0;
`endif
          end else r_state <= DATA;
        end
        DATA: if (w_acc) begin
`ifdef MIPS32_LOADER_CKSUM_EN
          r_sum <= r_sum ^ bus.in_data;
`endif
          if (w_word_done) begin
            r_addr <= r_wcnt[ADDR_W-1:0];
            r_wcnt <= r_wcnt + 1'b1;
          end
          if (w_last) begin
`ifdef MIPS32_LOADER_CKSUM_EN
            r_state <= CKSUM;
`else
            r_state <= START;
            r_start <= 1'b1;
            r_hold <= 1'b0;
`endif
          end
        end
`ifdef MIPS32_LOADER_CKSUM_EN
        CKSUM: if (w_acc) begin
          if (bus.in_data == r_sum) begin
            r_state <= START;
            r_start <= 1'b1;
            r_hold <= 1'b0;
          end else begin
            r_state <= IDLE;
            r_err <= 1'b1;
          end
        end
`endif
        START: r_state <= IDLE;
        default: ;
      endcase
    end
  end
  assign bus.in_ready = r_state != START;
  assign bus.mem_we = w_we;
  assign bus.mem_addr = r_addr;
  assign bus.mem_wdata = w_word;
  assign bus.cpu_hold = r_hold;
  assign bus.cpu_start = r_start;
  assign bus.busy = r_state != IDLE;
  assign bus.err = r_err;
endmodule

// File: tb/tb_mips32_prog_loader.sv
// tb_mips32_prog_loader: scoreboard bench; expected writes/start pulses are queued by the driver and popped by a monitor.
module tb_mips32_prog_loader;
  typedef struct {logic [9:0] addr; logic [31:0] data; time t;} wr_t;
  logic clk1 = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  wr_t wq[$];
  time sq[$];
  logic [31:0] img [9] = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
                           32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
  always #5 clk1 = ~clk1;
  mips32_prog_loader_if #(.ADDR_W(10)) bus();
  mips32_prog_loader #(.ADDR_W(10)) dut (.clk1(clk1), .rst(rst), .bus(bus));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk1) begin
    if (bus.mem_we) begin
      if (wq.size() == 0) chk("unexpected_write", 64'(bus.mem_addr), 64'h3ff_dead);
      else begin
        wr_t e;
        e = wq.pop_front();
        chk("wr_addr", 64'(bus.mem_addr), 64'(e.addr));
        chk("wr_data", 64'(bus.mem_wdata), 64'(e.data));
        chk("wr_time", 64'($time), 64'(e.t));
      end
    end
    if (bus.cpu_start) begin
      if (sq.size() == 0) chk("unexpected_start", 64'($time), 64'h0);
      else begin
        chk("start_time", 64'($time), 64'(sq.pop_front()));
        chk("hold_at_start", 64'(bus.cpu_hold), 64'h0);
      end
    end
  end

  task automatic send(input logic [7:0] b, output time ta);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = b;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk1);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("ready_timeout", 64'h0, 64'h1);
    @(posedge clk1);
    ta = $time;
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk1);
    if (n > 0) #1;
  endtask

  task automatic frame(input logic [15:0] nf, input int nw, input int gap, input logic [7:0] ck_flip,
                       input bit exp_start, input int max_bytes);
    time ta;
    logic [7:0] ck, b;
    int cnt;
    ck = 8'h00;
    cnt = 0;
    send(nf[15:8], ta);
    idle(gap);
    send(nf[7:0], ta);
    for (int i = 0; i < nw; i++)
      for (int j = 0; j < 4; j++) begin
        if (cnt == max_bytes) return;
        b = img[i][31-8*j -: 8];
        ck ^= b;
        idle(gap);
        send(b, ta);
        cnt++;
        if (j == 3) wq.push_back('{10'(i), img[i], ta + 5});
      end
`ifdef MIPS32_LOADER_CKSUM_EN
    idle(gap);
    send(ck ^ ck_flip, ta);
`endif
    if (exp_start) sq.push_back(ta + 5);
    idle(3);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'h1);
    chk({tag, "_mem_we"}, 64'(bus.mem_we), 64'h0);
    chk({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'h0);
    chk({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'h0);
    chk({tag, "_cpu_hold"}, 64'(bus.cpu_hold), 64'h1);
    chk({tag, "_cpu_start"}, 64'(bus.cpu_start), 64'h0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'h0);
    chk({tag, "_err"}, 64'(bus.err), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    time ta;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    idle(3);
    chk_reset_vals("rst");
    rst = 1'b0;
    idle(1);
    frame(16'd9, 9, 0, 8'h00, 1'b1, -1);
    chk("b2b_err", 64'(bus.err), 64'h0);
    chk("b2b_hold", 64'(bus.cpu_hold), 64'h0);
    chk("b2b_busy", 64'(bus.busy), 64'h0);
    frame(16'd9, 9, 1, 8'h00, 1'b1, -1);
    chk("gap_hold", 64'(bus.cpu_hold), 64'h0);
    frame(16'd0, 0, 0, 8'h00, 1'b1, -1);
    chk("n0_err", 64'(bus.err), 64'h0);
    chk("n0_hold", 64'(bus.cpu_hold), 64'h0);
`ifdef MIPS32_LOADER_CKSUM_EN
    frame(16'd9, 9, 0, 8'h5a, 1'b0, -1);
    chk("badck_err", 64'(bus.err), 64'h1);
    chk("badck_hold", 64'(bus.cpu_hold), 64'h1);
    frame(16'd9, 9, 0, 8'h00, 1'b1, -1);
    chk("goodck_err", 64'(bus.err), 64'h0);
    chk("goodck_hold", 64'(bus.cpu_hold), 64'h0);
`endif
    frame(16'd9, 9, 0, 8'h00, 1'b0, 6);
    chk("abort_busy", 64'(bus.busy), 64'h1);
    chk("abort_hold", 64'(bus.cpu_hold), 64'h1);
    chk("abort_one_write", 64'(wq.size()), 64'h0);
    rst = 1'b1;
    idle(1);
    chk_reset_vals("abort");
    rst = 1'b0;
    idle(1);
    frame(16'd9, 9, 0, 8'h00, 1'b1, -1);
    chk("reload_hold", 64'(bus.cpu_hold), 64'h0);
    send(8'h04, ta);
    send(8'h01, ta);
    chk("big_err", 64'(bus.err), 64'h1);
    chk("big_busy", 64'(bus.busy), 64'h1);
    for (int i = 0; i < 8; i++) send(8'(8'h11 * i), ta);
    chk("big_ready", 64'(bus.in_ready), 64'h1);
    chk("big_err_sticky", 64'(bus.err), 64'h1);
    chk("big_hold", 64'(bus.cpu_hold), 64'h1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("big_rst_err", 64'(bus.err), 64'h0);
    chk("big_rst_busy", 64'(bus.busy), 64'h0);
    idle(4);
    chk("wq_empty", 64'(wq.size()), 64'h0);
    chk("sq_empty", 64'(sq.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mips32_prog_loader.md
# mips32_prog_loader

Byte-stream program loader for `pipe_MIPS32`. It receives a framed program image over a valid/ready byte interface, packs it into 32-bit big-endian words, and writes them to the processor's instruction/data memory from address 0. After a complete, valid frame it releases the processor with a start pulse. It replaces hierarchical `Mem[]`/`PC`/`HALTED` pokes with a synthesizable write-side path into the core.

## Interface
- `ADDR_W`, default 10: memory word-address width; the maximum image is 2^ADDR_W words.
- `clk1`  in  1  phase-1 clock of the core; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  byte available on `in_data`.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts the byte; a transfer occurs when `in_valid & in_ready`.
- `mem_we`  out  1  one-cycle memory write strobe.
- `mem_addr`  out  ADDR_W  word address for the write.
- `mem_wdata`  out  32  word to write.
- `cpu_hold`  out  1  drives the core's HALTED/PC-reset hold; high means the core is held.
- `cpu_start`  out  1  one-cycle pulse; the core loads PC=0 and clears HALTED and TAKEN_BRANCH.
- `busy`  out  1  a frame is in progress (any state other than IDLE).
- `err`  out  1  sticky error flag for the last frame.

## Operation
- Frame format: LEN_HI, LEN_LO (N = word count, 16-bit big-endian), then 4·N payload bytes, MSB of each word first. A checksum byte follows the payload when the checksum feature is enabled (see Configuration).
- States:
  - IDLE → LEN_LO on the first byte; that byte is latched as LEN_HI.
  - LEN_LO → DATA if N > 0; otherwise → CKSUM or START.
  - If N > 2^ADDR_W: → ERR.
  - DATA → CKSUM or START after the 4·N-th byte.
  - CKSUM → START on a match; → IDLE with `err`=1 on a mismatch.
  - START lasts one cycle, then → IDLE.
  - ERR stays put until `rst`. In ERR, `in_ready`=1 and all bytes are discarded.
- Byte counter: 2 bits, wraps 3→0 at each word boundary. Word counter: ADDR_W+1 bits, starts at 0, increments after each write, and never exceeds N.
- `cpu_hold` is 1 from reset. It falls to 0 in the same cycle `cpu_start` pulses. It returns to 1 when the first byte of a new frame is accepted in IDLE.
- `err` clears when the first byte of a new frame is accepted, except in ERR, where only `rst` clears it.
- On a checksum mismatch, already-written words stay in memory, but `cpu_start` is not issued and `cpu_hold` stays 1.

## Timing
- Reset values: `in_ready`=1, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_hold`=1, `cpu_start`=0, `busy`=0, `err`=0; state is IDLE.
- `in_ready` is 1 in every state except START. The loader never stalls mid-frame, so back-to-back bytes are accepted at one per cycle.
- Write latency: if the 4th byte of a word is accepted at edge t, then `mem_we`=1 with the valid address and data during cycle t+1, for exactly one cycle.
- `cpu_start` pulses in the cycle after the last accepted byte (last payload byte, or the checksum byte). The last `mem_we` and `cpu_start` can coincide; the core must sample memory no earlier than the following `clk1` edge.
- A `rst` asserted mid-frame aborts the frame with no further writes, restores the reset values, and leaves a partial image in memory.
- If `in_valid` is low between bytes, state is held with no timeout.

## Configuration
- `MIPS32_LOADER_CKSUM_EN`:
  - Defined: a trailing XOR of all payload bytes, seeded with 0x00, is expected and checked; the length bytes are not included. A mismatch sets `err`.
  - Undefined: the CKSUM state is absent, the frame ends after the payload, and `err` is raised only by oversize N.

## Structure
- Shared package `mips32_pkg`:
  - loader state enum (IDLE, LEN_LO, DATA, CKSUM, START, ERR);
  - `HLT_OPCODE` = 6'h3f;
  - `WORD_BYTES` = 4.
- Sub-module `mips32_byte_packer`: 2-bit byte counter, 32-bit shift register, `word_valid` pulse. It is reused by the future register-dump path.

## Test plan
- Reset, then frame N=9 with the 9-instruction image (0x2801000a, 0x28020014, 0x28030019, 0x0ce77800 ×2, 0x00222000, 0x0ce77800, 0x00832800, 0xfc000000) plus the correct checksum, back-to-back → 9 writes at addresses 0–8 with matching data, then one `cpu_start` pulse; after the run, R4=30 and R5=55.
- Same frame with `in_valid` toggling every other cycle → identical writes; `mem_we` lands exactly one cycle after each 4th byte.
- N=0 (with checksum 0x00 when enabled) → no writes, `cpu_start` pulses, `err`=0.
- N=2^ADDR_W+1 → ERR, `err`=1, no writes, no `cpu_start`, `in_ready` stays 1; only `rst` recovers.
- Corrupted checksum byte (feature on) → all words written, `err`=1, `cpu_hold` stays 1; the next good frame clears `err` and starts the core.
- `rst` after 6 payload bytes → exactly 1 write seen, all outputs return to reset values, and a following frame loads normally.
